// File: rtl/param_word_serializer.sv
// Word-to-beat serializer for the Simon output stage.
// One active word plus a one-word pending buffer; per-word MSB/LSB beat order.
module param_word_serializer #(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int BEATS = DATA_W / BEAT_W;
    localparam int CW    = $clog2(BEATS);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    logic [0:0]        state;
    logic [DATA_W-1:0] act_word;
    logic              act_msb;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] pend_word;
    logic              pend_msb;
    logic              pend_full;

    logic          accept;
    logic          xfer;
    logic          at_last;
    logic          last_xfer;
    logic [CW-1:0] idx;

    assign in_ready  = !pend_full;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == SHIFT);
    assign xfer      = out_valid && out_ready;
    assign at_last   = (cnt == LAST_CNT);
    assign last_xfer = xfer && at_last;

    // MSB-first walks the word from the top beat down.
    assign idx      = act_msb ? (LAST_CNT - cnt) : cnt;
    assign out_data = out_valid ? act_word[idx*BEAT_W +: BEAT_W] : '0;
    assign out_last = out_valid && at_last;
    assign busy     = out_valid || pend_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            act_word  <= '0;
            act_msb   <= 1'b0;
            cnt       <= '0;
            pend_word <= '0;
            pend_msb  <= 1'b0;
            pend_full <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last_xfer;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        act_word <= in_data;
                        act_msb  <= in_msb_first;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) begin
                        cnt <= '0;
                        if (pend_full) begin
                            act_word  <= pend_word;
                            act_msb   <= pend_msb;
                            pend_full <= 1'b0;
                        end else if (accept) begin
                            act_word <= in_data;
                            act_msb  <= in_msb_first;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            cnt <= cnt + CW'(1);
                        end
                        if (accept) begin
                            pend_word <= in_data;
                            pend_msb  <= in_msb_first;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_word_serializer.sv
// Bench for param_word_serializer: directed table, corner sequences,
// and randomized traffic against a beat-queue reference model.
module tb_param_word_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        v_in_valid;
    logic        v_in_ready;
    logic [15:0] v_in_data;
    logic        v_msb;
    logic        v_out_valid;
    logic        v_out_ready;
    logic [7:0]  v_out_data;
    logic        v_out_last;
    logic        v_busy;
    logic        v_done;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    param_word_serializer #(.DATA_W(32), .BEAT_W(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    param_word_serializer #(.DATA_W(16), .BEAT_W(8)) u_dut16 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (v_in_valid),
        .in_ready     (v_in_ready),
        .in_data      (v_in_data),
        .in_msb_first (v_msb),
        .out_valid    (v_out_valid),
        .out_ready    (v_out_ready),
        .out_data     (v_out_data),
        .out_last     (v_out_last),
        .busy         (v_busy),
        .done         (v_done)
    );

    typedef struct {
        string       name;
        logic [31:0] word;
        logic        msb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; exp lists the beats in transmit order, top nibble first.
    task automatic run_word(input logic [31:0] w, input logic m,
                            input logic [31:0] e, input string nm);
        in_valid     = 1'b1;
        in_data      = w;
        in_msb_first = m;
        out_ready    = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
        in_msb_first = !m;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk({nm, " valid"}, 32'(out_valid), 32'd1);
            chk({nm, " beat"}, 32'(out_data), 32'(e[31-4*k -: 4]));
            chk({nm, " last"}, 32'(out_last), 32'(k == 7));
            chk({nm, " done_early"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
        chk({nm, " valid_end"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({nm, " done_once"}, 32'(done), 32'd0);
    endtask

    function automatic logic [3:0] beat_of(input logic [31:0] w,
                                           input logic m, input int k);
        int sh;
        sh = m ? (7 - k) * 4 : k * 4;
        return 4'((w >> sh) & 32'hF);
    endfunction

    logic [4:0] q[$];
    logic       done_exp;
    logic       acc;
    logic       xf;
    logic [4:0] head;

    initial begin
        vt[0] = '{"t1_msb", 32'h12345678, 1'b1, 32'h12345678};
        vt[1] = '{"t2_lsb", 32'h12345678, 1'b0, 32'h87654321};
        vt[2] = '{"a5_lsb", 32'hA5A5F00F, 1'b0, 32'hF00F5A5A};
        vt[3] = '{"dead_msb", 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vt[4] = '{"zero_c", 32'h0000000C, 1'b1, 32'h0000000C};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_msb_first = 1'b0;
        out_ready    = 1'b0;
        v_in_valid   = 1'b0;
        v_in_data    = '0;
        v_msb        = 1'b0;
        v_out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++)
            run_word(vt[i].word, vt[i].msb, vt[i].exp, vt[i].name);

        // Backpressure during beat 2
        in_valid     = 1'b1;
        in_data      = 32'hA5A5F00F;
        in_msb_first = 1'b1;
        out_ready    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp beat0", 32'(out_data), 32'hA);
        @(negedge clk);
        chk("bp beat1", 32'(out_data), 32'h5);
        @(negedge clk);
        chk("bp beat2", 32'(out_data), 32'hA);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp hold data", 32'(out_data), 32'hA);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 3; k < 8; k++) begin
            @(negedge clk);
            chk("bp beat", 32'(out_data), 32'(beat_of(32'hA5A5F00F, 1'b1, k)));
            chk("bp last", 32'(out_last), 32'(k == 7));
            chk("bp no done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("bp done", 32'(done), 32'd1);

        // Back-to-back three words, third waits for the pending slot
        in_valid     = 1'b1;
        in_data      = 32'h11111111;
        in_msb_first = 1'b1;
        out_ready    = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) in_data = 32'h22222222;
            if (i == 2) in_data = 32'h33333333;
            if (i == 10) in_valid = 1'b0;
            chk("b2b valid", 32'(out_valid), 32'(i <= 24));
            chk("b2b done", 32'(done), 32'(i == 9 || i == 17 || i == 25));
            if (i <= 24)
                chk("b2b beat", 32'(out_data), 32'((i + 7) / 8));
            if (i <= 9)
                chk("b2b in_ready", 32'(in_ready), 32'(i == 1 || i == 9));
        end
        @(negedge clk);

        // Reset in the middle of a word
        in_valid     = 1'b1;
        in_data      = 32'hDEADBEEF;
        in_msb_first = 1'b1;
        out_ready    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rmw beat3", 32'(out_data), 32'hD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmw out_valid", 32'(out_valid), 32'd0);
        chk("rmw done", 32'(done), 32'd0);
        chk("rmw busy", 32'(busy), 32'd0);
        chk("rmw in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rmw no done", 32'(done), 32'd0);
        run_word(32'h0000000C, 1'b1, 32'h0000000C, "rmw_after");

        // 16/8 variant
        for (int o = 0; o < 2; o++) begin
            v_in_valid = 1'b1;
            v_in_data  = 16'hBEEF;
            v_msb      = (o == 0);
            @(negedge clk);
            v_in_valid = 1'b0;
            chk("v16 beat0", 32'(v_out_data), (o == 0) ? 32'hBE : 32'hEF);
            chk("v16 last0", 32'(v_out_last), 32'd0);
            @(negedge clk);
            chk("v16 beat1", 32'(v_out_data), (o == 0) ? 32'hEF : 32'hBE);
            chk("v16 last1", 32'(v_out_last), 32'd1);
            chk("v16 no done", 32'(v_done), 32'd0);
            @(negedge clk);
            chk("v16 done", 32'(v_done), 32'd1);
            chk("v16 idle", 32'(v_out_valid), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic vs beat-queue model
        q.delete();
        done_exp = 1'b0;
        for (int i = 0; i < 3040; i++) begin
            @(negedge clk);
            chk("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd busy", 32'(busy), 32'(q.size() > 0));
            chk("rnd in_ready", 32'(in_ready), 32'(q.size() <= 8));
            chk("rnd done", 32'(done), 32'(done_exp));
            if (i < 3000) begin
                in_valid     = ($urandom_range(0, 9) < 6);
                in_data      = $urandom;
                in_msb_first = $urandom_range(0, 1) == 1;
                out_ready    = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            acc = in_valid && (q.size() <= 8);
            xf  = out_ready && (q.size() > 0);
            done_exp = 1'b0;
            if (xf) begin
                head = q.pop_front();
                chk("rnd beat", 32'(out_data), 32'(head[3:0]));
                chk("rnd last", 32'(out_last), 32'(head[4]));
                done_exp = head[4];
            end
            if (acc)
                for (int k = 0; k < 8; k++)
                    q.push_back({k == 7, beat_of(in_data, in_msb_first, k)});
        end
        chk("rnd drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
